ddr_dqs_sched: RTL and testbench

Write-burst scheduler and DQS pattern generator for one DDR byte lane. Accepts write-burst requests from the memory controller on a valid/ready handshake, delays them by the write latency, and produces per-`pclk` 8-bit DQS words and tristate controls for the lane's 8:1 differential serializer, including preamble, postamble and seamless back-to-back bursts. It also emits the DQ output-enable and a one-cycle-early data-fetch strobe. One serializer word equals 4 tCK, which is one BL8 burst.

---
 rtl/ddr_phy_pkg.sv | 28 ++
 rtl/ddr_dqs_encode.sv | 31 +++
 rtl/ddr_dqs_sched.sv | 94 +++++++++
 tb/tb_ddr_dqs_sched.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/ddr_phy_pkg.sv
// Shared constants and helpers for the DDR byte-lane PHY blocks.
package ddr_phy_pkg;

    // Serializer DQS words; bit 0 goes out first.
    localparam logic [7:0] DQS_BURST = 8'h55;
    localparam logic [7:0] DQS_LOW   = 8'h00;

    // Tristate patterns for the 8:1 serializer, one bit per tCK (bit k covers bits 2k..2k+1).
    // A 1 puts the pad in high-Z.
    localparam logic [3:0] TX_BURST = 4'b0000;
    localparam logic [3:0] TX_PRE   = 4'b0111;  // only the last tCK driven low
    localparam logic [3:0] TX_POST  = 4'b1110;  // only the first tCK driven low
    localparam logic [3:0] TX_GAP   = 4'b0110;  // postamble and preamble share one word
    localparam logic [3:0] TX_IDLE  = 4'b1111;

    localparam int unsigned LAT_MIN = 2;
    localparam int unsigned LAT_MAX = 15;

    typedef enum logic {
        StIdle,
        StIssue
    } sched_state_e;

    function automatic bit lat_ok(input int unsigned lat);
        return (lat >= LAT_MIN) && (lat <= LAT_MAX);
    endfunction

endpackage

// File: rtl/ddr_dqs_encode.sv
// Maps the schedule taps around the output stage to one DQS serializer word.
module ddr_dqs_encode
    import ddr_phy_pkg::*;
(
    input  logic       now_i,
    input  logic       nxt_i,
    input  logic       prv_i,
    output logic [7:0] dqs_d_o,
    output logic [3:0] dqs_tx_o,
    output logic       dq_oe_o
);

    // Priority decode: burst, gap, preamble, postamble, idle.
    always_comb begin
        dqs_d_o  = DQS_LOW;
        dqs_tx_o = TX_IDLE;
        dq_oe_o  = 1'b0;
        if (now_i) begin
            dqs_d_o  = DQS_BURST;
            dqs_tx_o = TX_BURST;
            dq_oe_o  = 1'b1;
        end else if (nxt_i && prv_i) begin
            dqs_tx_o = TX_GAP;
        end else if (nxt_i) begin
            dqs_tx_o = TX_PRE;
        end else if (prv_i) begin
            dqs_tx_o = TX_POST;
        end
    end

endmodule

// File: rtl/ddr_dqs_sched.sv
// Write-burst scheduler and DQS pattern generator for one DDR byte lane.
module ddr_dqs_sched
    import ddr_phy_pkg::*;
#(
    parameter int unsigned LAT = 4
) (
    input  logic       pclk,
    input  logic       rst,
    input  logic       en,
    input  logic       wr_valid,
    input  logic [3:0] wr_len,
    output logic       wr_ready,
    output logic [7:0] dqs_d,
    output logic [3:0] dqs_tx,
    output logic       dq_oe,
    output logic       dq_req,
    output logic       busy
);

    if (!lat_ok(LAT)) begin : g_lat_check
        $error("ddr_dqs_sched: LAT must be within 2..15");
    end

    sched_state_e st;
    logic [3:0]   cnt_q, cnt_d;
    logic [LAT:0] sched_q, sched_d;
    logic         accept, insert;
    logic         now, nxt, prv;
    logic [7:0]   enc_d;
    logic [3:0]   enc_tx;
    logic         enc_oe;
    logic [7:0]   dqs_d_q;
    logic [3:0]   dqs_tx_q;
    logic         dq_oe_q, dq_req_q;

    // Output stage sits at LAT-1 so the registered word lands LAT cycles after accept.
    assign now = sched_q[LAT-1];
    assign nxt = sched_q[LAT-2];
    assign prv = sched_q[LAT];

    // State register: remaining-beat counter, schedule pipe and registered lane outputs.
    always_ff @(posedge pclk) begin
        if (rst) begin
            cnt_q    <= '0;
            sched_q  <= '0;
            dqs_d_q  <= DQS_LOW;
            dqs_tx_q <= TX_IDLE;
            dq_oe_q  <= 1'b0;
            dq_req_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            sched_q  <= sched_d;
            dqs_d_q  <= enc_d;
            dqs_tx_q <= enc_tx;
            dq_oe_q  <= enc_oe;
            dq_req_q <= nxt;
        end
    end

    // Next state: load the beat count on accept, otherwise drain one beat per cycle.
    always_comb begin
        cnt_d   = cnt_q;
        sched_d = {sched_q[LAT-1:0], insert};
        case (st)
            StIdle:  cnt_d = accept ? wr_len : '0;
            StIssue: cnt_d = cnt_q - 4'd1;
            default: cnt_d = '0;
        endcase
    end

    // Outputs: handshake, beat insertion and activity flag from registered state.
    always_comb begin
        st       = (cnt_q == '0) ? StIdle : StIssue;
        wr_ready = en && (st == StIdle) && !rst;
        accept   = wr_valid && wr_ready;
        insert   = accept || (st == StIssue);
        busy     = (cnt_q != '0) || (|sched_q);
    end

    ddr_dqs_encode u_encode (
        .now_i    (now),
        .nxt_i    (nxt),
        .prv_i    (prv),
        .dqs_d_o  (enc_d),
        .dqs_tx_o (enc_tx),
        .dq_oe_o  (enc_oe)
    );

    assign dqs_d  = dqs_d_q;
    assign dqs_tx = dqs_tx_q;
    assign dq_oe  = dq_oe_q;
    assign dq_req = dq_req_q;

endmodule

// File: tb/tb_ddr_dqs_sched.sv
// Directed bench for ddr_dqs_sched with LAT=4; windows are indexed from the accept edge.
module tb_ddr_dqs_sched;

    localparam int unsigned LAT = 4;
    localparam int          WIN = 20;

    logic       pclk = 1'b0;
    logic       rst;
    logic       en;
    logic       wr_valid;
    logic [3:0] wr_len;
    logic       wr_ready;
    logic [7:0] dqs_d;
    logic [3:0] dqs_tx;
    logic       dq_oe;
    logic       dq_req;
    logic       busy;

    int checks = 0;
    int errors = 0;

    logic [7:0] rec_d   [WIN];
    logic [3:0] rec_tx  [WIN];
    logic       rec_oe  [WIN];
    logic       rec_req [WIN];
    logic       rec_rdy [WIN];
    logic [3:0] exp_tx  [WIN];
    logic       exp_req [WIN];

    always #5 pclk = ~pclk;

    ddr_dqs_sched #(.LAT(LAT)) dut (
        .pclk     (pclk),
        .rst      (rst),
        .en       (en),
        .wr_valid (wr_valid),
        .wr_len   (wr_len),
        .wr_ready (wr_ready),
        .dqs_d    (dqs_d),
        .dqs_tx   (dqs_tx),
        .dq_oe    (dq_oe),
        .dq_req   (dq_req),
        .busy     (busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge pclk);
        #1;
    endtask

    task automatic sample(input int i);
        rec_d[i]   = dqs_d;
        rec_tx[i]  = dqs_tx;
        rec_oe[i]  = dq_oe;
        rec_req[i] = dq_req;
        rec_rdy[i] = wr_ready;
    endtask

    task automatic clear_exp();
        for (int i = 0; i < WIN; i++) begin
            exp_tx[i]  = 4'b1111;
            exp_req[i] = 1'b0;
        end
    endtask

    // Compares the recorded DQS word stream; d/oe follow from whether tx is the burst pattern.
    task automatic check_window(input string name, input int n);
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s_tx[%0d]", name, i), 32'(rec_tx[i]), 32'(exp_tx[i]));
            check($sformatf("%s_d[%0d]", name, i), 32'(rec_d[i]),
                  (exp_tx[i] == 4'b0000) ? 32'h55 : 32'h00);
            check($sformatf("%s_oe[%0d]", name, i), 32'(rec_oe[i]),
                  32'(exp_tx[i] == 4'b0000));
            check($sformatf("%s_req[%0d]", name, i), 32'(rec_req[i]), 32'(exp_req[i]));
        end
    endtask

    // Presents one request and returns just after the accepting edge (window index 0).
    task automatic accept(input logic [3:0] len);
        wr_valid = 1'b1;
        wr_len   = len;
        step();
        wr_valid = 1'b0;
    endtask

    initial begin
        rst      = 1'b1;
        en       = 1'b1;
        wr_valid = 1'b1;
        wr_len   = 4'd0;

        // Reset, including a request presented while reset is held.
        step();
        step();
        check("rst_ready", 32'(wr_ready), 32'd0);
        check("rst_tx", 32'(dqs_tx), 32'hf);
        check("rst_busy", 32'(busy), 32'd0);
        wr_valid = 1'b0;
        rst      = 1'b0;
        for (int i = 0; i < 20; i++) step();
        check("idle_tx", 32'(dqs_tx), 32'hf);
        check("idle_d", 32'(dqs_d), 32'h0);
        check("idle_oe", 32'(dq_oe), 32'd0);
        check("idle_req", 32'(dq_req), 32'd0);
        check("idle_busy", 32'(busy), 32'd0);
        check("idle_ready", 32'(wr_ready), 32'd1);

        // Single BL8 burst: pre at 3, burst at 4, post at 5.
        accept(4'd0);
        check("single_busy0", 32'(busy), 32'd1);
        for (int i = 0; i < 8; i++) begin
            sample(i);
            step();
        end
        clear_exp();
        exp_tx[3] = 4'b0111; exp_tx[4] = 4'b0000; exp_tx[5] = 4'b1110;
        exp_req[3] = 1'b1;
        check_window("single", 8);
        for (int i = 0; i < 4; i++) check($sformatf("single_rdy[%0d]", i), 32'(rec_rdy[i]), 32'd1);
        check("single_busy_end", 32'(busy), 32'd0);

        // Four beats then two beats, second request held until accepted: six gap-free bursts.
        wr_valid = 1'b1;
        wr_len   = 4'd3;
        step();
        wr_len = 4'd1;
        for (int i = 0; i < 13; i++) begin
            sample(i);
            if (i == 4) wr_valid = 1'b0;
            step();
        end
        clear_exp();
        exp_tx[3] = 4'b0111;
        for (int i = 4; i < 10; i++) exp_tx[i] = 4'b0000;
        exp_tx[10] = 4'b1110;
        for (int i = 3; i < 9; i++) exp_req[i] = 1'b1;
        check_window("b2b", 13);
        for (int i = 0; i < 3; i++) check($sformatf("b2b_rdy[%0d]", i), 32'(rec_rdy[i]), 32'd0);
        check("b2b_rdy[3]", 32'(rec_rdy[3]), 32'd1);
        check("b2b_rdy[4]", 32'(rec_rdy[4]), 32'd0);

        // Two single bursts two cycles apart share one gap word.
        accept(4'd0);
        for (int i = 0; i < 10; i++) begin
            sample(i);
            if (i == 1) begin
                wr_valid = 1'b1;
                wr_len   = 4'd0;
            end else begin
                wr_valid = 1'b0;
            end
            step();
        end
        clear_exp();
        exp_tx[3] = 4'b0111; exp_tx[4] = 4'b0000; exp_tx[5] = 4'b0110;
        exp_tx[6] = 4'b0000; exp_tx[7] = 4'b1110;
        exp_req[3] = 1'b1; exp_req[5] = 1'b1;
        check_window("gap", 10);

        // Enable dropped right after accepting eight beats: all beats still go out.
        accept(4'd7);
        en = 1'b0;
        for (int i = 0; i < 15; i++) begin
            sample(i);
            step();
        end
        clear_exp();
        exp_tx[3] = 4'b0111;
        for (int i = 4; i < 12; i++) exp_tx[i] = 4'b0000;
        exp_tx[12] = 4'b1110;
        for (int i = 3; i < 11; i++) exp_req[i] = 1'b1;
        check_window("en_off", 15);
        for (int i = 0; i < 15; i++) check($sformatf("en_off_rdy[%0d]", i), 32'(rec_rdy[i]), 32'd0);
        en = 1'b1;
        #1;
        check("en_back_rdy", 32'(wr_ready), 32'd1);

        // Reset during the third beat of an eight-beat burst.
        accept(4'd7);
        for (int i = 0; i < 6; i++) step();
        check("mid_beat3_tx", 32'(dqs_tx), 32'h0);
        check("mid_beat3_d", 32'(dqs_d), 32'h55);
        rst = 1'b1;
        step();
        check("mid_rst_tx", 32'(dqs_tx), 32'hf);
        check("mid_rst_d", 32'(dqs_d), 32'h0);
        check("mid_rst_oe", 32'(dq_oe), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_req", 32'(dq_req), 32'd0);
        check("mid_rst_ready", 32'(wr_ready), 32'd0);
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step();
            check($sformatf("post_rst_req[%0d]", i), 32'(dq_req), 32'd0);
            check($sformatf("post_rst_tx[%0d]", i), 32'(dqs_tx), 32'hf);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
